// File: rtl/store_align_pkg.sv
// Shared encodings and helpers for the store alignment path.
// Sizes follow the ISA store-width field; lanes are big-endian.
package store_align_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } state_e;

    // Byte-enable mask for an access starting at lane 0; reserved size enables nothing.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b1000;
            SZ_HALF: m = 4'b1100;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Left shift (in bits) that moves right-justified register data to the top of the word.
    function automatic logic [4:0] size_shift(input logic [1:0] size);
        logic [4:0] s;
        case (size)
            SZ_BYTE: s = 5'd24;
            SZ_HALF: s = 5'd16;
            default: s = 5'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane math: positions store data into a two-word window and
// derives both beats' address, data and byte enables plus the split flag.
module store_lane_shift
    import store_align_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] b0_addr,
    output logic [31:0]       b0_wdata,
    output logic [3:0]        b0_be,
    output logic [ADDR_W-1:0] b1_addr,
    output logic [31:0]       b1_wdata,
    output logic [3:0]        b1_be,
    output logic              split
);

    logic [1:0]  ofs;
    logic [31:0] left;
    logic [63:0] win;
    logic [7:0]  bewin;

    always_comb begin
        ofs   = addr[1:0];
        left  = data << size_shift(size);
        win   = {left, 32'h0} >> {ofs, 3'b000};
        bewin = {size_mask(size), 4'b0000} >> ofs;
    end

    // Second beat wraps modulo the address space.
    assign b0_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign b1_addr  = b0_addr + ADDR_W'(4);
    assign b0_wdata = win[63:32];
    assign b1_wdata = win[31:0];
    assign b0_be    = bewin[7:4];
    assign b1_be    = bewin[3:0];
    assign split    = (bewin[3:0] != 4'b0000);

endmodule

// File: rtl/store_align.sv
// Store aligner between EX/MEM and the data-memory write port: one beat per
// aligned store, two beats for word-crossing stores (or rejection when disabled).
module store_align
    import store_align_pkg::*;
#(
    parameter bit ALLOW_SPLIT = 1'b1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              busy,
    output logic              err_misaligned
);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] b0_addr, b1_addr, pend_addr;
    logic [31:0]       b0_wdata, b1_wdata, pend_wdata;
    logic [3:0]        b0_be, b1_be, pend_be;
    logic              split, split_q;
    logic              final_beat, accept, legal, load_new, load_pend;

    store_lane_shift #(.ADDR_W(ADDR_W)) u_lane (
        .addr     (req_addr),
        .data     (req_data),
        .size     (req_size),
        .b0_addr  (b0_addr),
        .b0_wdata (b0_wdata),
        .b0_be    (b0_be),
        .b1_addr  (b1_addr),
        .b1_wdata (b1_wdata),
        .b1_be    (b1_be),
        .split    (split)
    );

    // Accepting alongside the final handshake lets aligned stores stream one per cycle.
    always_comb begin
        final_beat = (state == ST_BEAT1) || ((state == ST_BEAT0) && !split_q);
        req_ready  = (state == ST_IDLE) || (final_beat && mem_ready);
        accept     = req_valid && req_ready;
        legal      = (req_size != SZ_RSVD) && (ALLOW_SPLIT || !split);
        load_new   = accept && legal;
        load_pend  = 1'b0;
        state_nxt  = state;
        case (state)
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (split_q) begin
                        state_nxt = ST_BEAT1;
                        load_pend = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (load_new) state_nxt = ST_BEAT0;
    end

    assign mem_valid = (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            split_q        <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            state          <= state_nxt;
            err_misaligned <= accept && !legal;
            if (load_new) split_q <= split;
        end
    end

    // Beat registers only change on a new accept or when advancing to beat 1,
    // which keeps the write port stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (load_new) begin
            mem_addr   <= b0_addr;
            mem_wdata  <= b0_wdata;
            mem_be     <= b0_be;
            pend_addr  <= b1_addr;
            pend_wdata <= b1_wdata;
            pend_be    <= b1_be;
        end else if (load_pend) begin
            mem_addr  <= pend_addr;
            mem_wdata <= pend_wdata;
            mem_be    <= pend_be;
        end
    end

endmodule

// File: tb/tb_store_align.sv
// Self-checking bench for store_align: vector table, hand sequences for
// stall/reset/error cases, and randomized traffic against a byte-level model.
module tb_store_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, mem_valid, mem_ready, busy, err_misaligned;
    logic [31:0] req_addr, req_data, mem_addr, mem_wdata;
    logic [1:0]  req_size;
    logic [3:0]  mem_be;

    logic        ns_req_valid, ns_req_ready, ns_mem_valid, ns_mem_ready, ns_busy, ns_err;
    logic [31:0] ns_req_addr, ns_req_data, ns_mem_addr, ns_mem_wdata;
    logic [1:0]  ns_req_size;
    logic [3:0]  ns_mem_be;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_align #(.ALLOW_SPLIT(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .busy(busy), .err_misaligned(err_misaligned)
    );

    store_align #(.ALLOW_SPLIT(1'b0), .ADDR_W(32)) dut_ns (
        .clk(clk), .reset(reset),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_addr(ns_req_addr),
        .req_data(ns_req_data), .req_size(ns_req_size),
        .mem_valid(ns_mem_valid), .mem_ready(ns_mem_ready), .mem_addr(ns_mem_addr),
        .mem_wdata(ns_mem_wdata), .mem_be(ns_mem_be),
        .busy(ns_busy), .err_misaligned(ns_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          nb;
        beat_t       b0;
        beat_t       b1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Byte-by-byte reference: byte i of the n-byte value (most significant first)
    // goes to address a+i; each byte lands in its word at big-endian lane position.
    function automatic int model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, output beat_t b0, output beat_t b1);
        int          n;
        int          lane;
        logic [31:0] ba;
        logic [31:0] w0;
        logic [7:0]  v;
        w0 = a & ~32'd3;
        b0 = '{w0, 32'h0, 4'h0};
        b1 = '{w0 + 32'd4, 32'h0, 4'h0};
        if (sz == 2'b11) return 0;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ba   = a + i;
            lane = int'(ba[1:0]);
            v    = d[8*(n-1-i) +: 8];
            if ((ba & ~32'd3) == w0) begin
                b0.wdata[8*(3-lane) +: 8] = v;
                b0.be[3-lane] = 1'b1;
            end else begin
                b1.wdata[8*(3-lane) +: 8] = v;
                b1.be[3-lane] = 1'b1;
            end
        end
        return (b1.be != 4'h0) ? 2 : 1;
    endfunction

    task automatic chk_beat(input string nm, input beat_t b);
        chk({nm, "_valid"}, mem_valid, 1);
        chk({nm, "_addr"}, mem_addr, b.addr);
        chk({nm, "_wdata"}, mem_wdata, b.wdata);
        chk({nm, "_be"}, mem_be, b.be);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size; mem_ready = 1'b1;
        #1 chk($sformatf("vec%0d_ready", idx), req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk_beat($sformatf("vec%0d_b0", idx), v.b0);
        if (v.nb == 2) begin
            @(negedge clk);
            #1 chk_beat($sformatf("vec%0d_b1", idx), v.b1);
        end
        @(negedge clk);
        #1 chk($sformatf("vec%0d_idle", idx), mem_valid, 0);
    endtask

    vec_t        vecs[10];
    beat_t       expq[$];
    beat_t       mb0, mb1;
    int          nb;
    logic        err_exp;
    logic        rdy_exp;

    initial begin
        vecs[0] = '{2'b00, 32'h1003, 32'h000000AB, 1, '{32'h1000, 32'h000000AB, 4'b0001}, '{32'h0, 32'h0, 4'h0}};
        vecs[1] = '{2'b01, 32'h2000, 32'h0000BEEF, 1, '{32'h2000, 32'hBEEF0000, 4'b1100}, '{32'h0, 32'h0, 4'h0}};
        vecs[2] = '{2'b10, 32'h2004, 32'h12345678, 1, '{32'h2004, 32'h12345678, 4'b1111}, '{32'h0, 32'h0, 4'h0}};
        vecs[3] = '{2'b10, 32'h3001, 32'hAABBCCDD, 2, '{32'h3000, 32'h00AABBCC, 4'b0111}, '{32'h3004, 32'hDD000000, 4'b1000}};
        vecs[4] = '{2'b01, 32'hFFFFFFFF, 32'h00001234, 2, '{32'hFFFFFFFC, 32'h00000012, 4'b0001}, '{32'h0, 32'h34000000, 4'b1000}};
        vecs[5] = '{2'b00, 32'h5000, 32'hFFFFFF5A, 1, '{32'h5000, 32'h5A000000, 4'b1000}, '{32'h0, 32'h0, 4'h0}};
        vecs[6] = '{2'b01, 32'h5001, 32'h0000CAFE, 1, '{32'h5000, 32'h00CAFE00, 4'b0110}, '{32'h0, 32'h0, 4'h0}};
        vecs[7] = '{2'b01, 32'h5002, 32'hFFFFCAFE, 1, '{32'h5000, 32'h0000CAFE, 4'b0011}, '{32'h0, 32'h0, 4'h0}};
        vecs[8] = '{2'b10, 32'h6003, 32'h11223344, 2, '{32'h6000, 32'h00000011, 4'b0001}, '{32'h6004, 32'h22334400, 4'b1110}};
        vecs[9] = '{2'b10, 32'h6002, 32'h11223344, 2, '{32'h6000, 32'h00001122, 4'b0011}, '{32'h6004, 32'h33440000, 4'b1100}};

        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b1;
        ns_req_valid = 1'b0; ns_req_addr = '0; ns_req_data = '0; ns_req_size = '0; ns_mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", mem_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_misaligned, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_ns_valid", ns_mem_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Back-to-back half then word with req_ready held high.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h2000; req_data = 32'h0000BEEF; req_size = 2'b01; mem_ready = 1'b1;
        #1 chk("b2b_ready0", req_ready, 1);
        @(negedge clk);
        req_addr = 32'h2004; req_data = 32'h12345678; req_size = 2'b10;
        #1 chk("b2b_ready1", req_ready, 1);
        chk_beat("b2b_half", '{32'h2000, 32'hBEEF0000, 4'b1100});
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk_beat("b2b_word", '{32'h2004, 32'h12345678, 4'b1111});
        @(negedge clk);
        #1 chk("b2b_idle", mem_valid, 0);

        // Stall on an aligned word with another request waiting.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h4000; req_data = 32'hCAFEF00D; req_size = 2'b10; mem_ready = 1'b0;
        #1 chk("stall_acc", req_ready, 1);
        @(negedge clk);
        req_addr = 32'h4100; req_data = 32'h01020304;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_beat($sformatf("stall%0d", i), '{32'h4000, 32'hCAFEF00D, 4'b1111});
            chk($sformatf("stall%0d_ready", i), req_ready, 0);
            chk($sformatf("stall%0d_busy", i), busy, 1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1 chk("stall_rel_ready", req_ready, 1);
        chk_beat("stall_rel", '{32'h4000, 32'hCAFEF00D, 4'b1111});
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk_beat("stall_next", '{32'h4100, 32'h01020304, 4'b1111});
        @(negedge clk);
        #1 chk("stall_idle", mem_valid, 0);
        chk("stall_idle_busy", busy, 0);

        // Reserved size: accepted, no beat, one-cycle error.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h7000; req_data = 32'h55; req_size = 2'b11;
        #1 chk("rsvd_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("rsvd_err1", err_misaligned, 1);
        chk("rsvd_valid1", mem_valid, 0);
        @(negedge clk);
        #1 chk("rsvd_err2", err_misaligned, 0);
        chk("rsvd_valid2", mem_valid, 0);

        // Split disabled: misaligned word and crossing half are dropped; aligned word still issues.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ns_req_valid = 1'b1; ns_req_addr = (k == 0) ? 32'h3001 : 32'h8003;
            ns_req_data = 32'hAABBCCDD; ns_req_size = (k == 0) ? 2'b10 : 2'b01;
            #1 chk($sformatf("ns%0d_ready", k), ns_req_ready, 1);
            @(negedge clk);
            ns_req_valid = 1'b0;
            #1 chk($sformatf("ns%0d_err1", k), ns_err, 1);
            chk($sformatf("ns%0d_valid1", k), ns_mem_valid, 0);
            @(negedge clk);
            #1 chk($sformatf("ns%0d_err2", k), ns_err, 0);
            chk($sformatf("ns%0d_valid2", k), ns_mem_valid, 0);
        end
        @(negedge clk);
        ns_req_valid = 1'b1; ns_req_addr = 32'h8000; ns_req_data = 32'hDEADBEEF; ns_req_size = 2'b10;
        @(negedge clk);
        ns_req_valid = 1'b0;
        #1 chk("ns_al_valid", ns_mem_valid, 1);
        chk("ns_al_wdata", ns_mem_wdata, 32'hDEADBEEF);
        chk("ns_al_be", ns_mem_be, 4'b1111);
        chk("ns_al_err", ns_err, 0);
        @(negedge clk);
        #1 chk("ns_al_idle", ns_mem_valid, 0);

        // Reset during beat 0 of a split store aborts it.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h3001; req_data = 32'hAABBCCDD; req_size = 2'b10; mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk_beat("rstmid_b0", '{32'h3000, 32'h00AABBCC, 4'b0111});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        #1 chk("rstmid_valid", mem_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_addr", mem_addr, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk($sformatf("rstmid_quiet%0d", i), mem_valid, 0);
        end

        // Randomized traffic against the byte-level model.
        err_exp = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            req_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            req_data  = $urandom;
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy_exp = (expq.size() == 0) || ((expq.size() == 1) && mem_ready);
            chk("rnd_err", err_misaligned, err_exp);
            chk("rnd_valid", mem_valid, (expq.size() != 0));
            chk("rnd_ready", req_ready, rdy_exp);
            if (mem_valid && expq.size() != 0) begin
                chk("rnd_addr", mem_addr, expq[0].addr);
                chk("rnd_wdata", mem_wdata, expq[0].wdata);
                chk("rnd_be", mem_be, expq[0].be);
                if (mem_ready) void'(expq.pop_front());
            end
            err_exp = 1'b0;
            if (req_valid && rdy_exp) begin
                nb = model(req_addr, req_data, req_size, mb0, mb1);
                if (nb == 0) err_exp = 1'b1;
                if (nb >= 1) expq.push_back(mb0);
                if (nb == 2) expq.push_back(mb1);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
